// File: rtl/ccip_rdreq_arbiter.sv
// Round-robin arbiter sharing the CCI-P C0 Tx read-request channel between
// NUM_REQ requesters. Requests are tagged with {seq, id} in mdata, each
// requester is limited to MAX_OUTSTANDING in-flight reads, and C0 Rx read
// responses are steered back to the requester named in the returned tag.
module ccip_rdreq_arbiter #(
  parameter int unsigned NUM_REQ         = 4,
  parameter int unsigned MAX_OUTSTANDING = 8,
  parameter int unsigned ADDR_WIDTH      = 42
) (
  input  logic                          clk,
  input  logic                          SoftReset_n,
  input  logic                          arb_enable,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*2-1:0]          req_vc,
  input  logic [NUM_REQ*4-1:0]          req_reqtype,
  input  logic                          C0TxAlmFull,
  output logic                          C0TxRdValid,
  output logic [1:0]                    C0TxHdr_vc,
  output logic [3:0]                    C0TxHdr_reqtype,
  output logic [ADDR_WIDTH-1:0]         C0TxHdr_addr,
  output logic [15:0]                   C0TxHdr_mdata,
  input  logic                          C0RxRdValid,
  input  logic [15:0]                   C0RxHdr_mdata,
  input  logic [511:0]                  C0RxData,
  output logic [NUM_REQ-1:0]            rsp_valid,
  output logic [511:0]                  rsp_data,
  output logic [7:0]                    rsp_seq,
  output logic [NUM_REQ*8-1:0]          outstanding,
  output logic                          idle,
  output logic                          err_badtag,
  output logic                          err_underflow
);

  localparam int unsigned PtrW   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [7:0]  MaxOut = 8'(MAX_OUTSTANDING);

  // State
  logic [PtrW-1:0]       rr_ptr_q, rr_ptr_d;
  logic [7:0]            seq_q [NUM_REQ];
  logic [7:0]            seq_d [NUM_REQ];
  logic [7:0]            cnt_q [NUM_REQ];
  logic [7:0]            cnt_d [NUM_REQ];
  logic                  tx_valid_q, tx_valid_d;
  logic [1:0]            tx_vc_q, tx_vc_d;
  logic [3:0]            tx_type_q, tx_type_d;
  logic [ADDR_WIDTH-1:0] tx_addr_q, tx_addr_d;
  logic [15:0]           tx_mdata_q, tx_mdata_d;
  logic [NUM_REQ-1:0]    rsp_valid_q, rsp_valid_d;
  logic [511:0]          rsp_data_q, rsp_data_d;
  logic [7:0]            rsp_seq_q, rsp_seq_d;
  logic                  err_badtag_q, err_badtag_d;
  logic                  err_underflow_q, err_underflow_d;

  // Arbitration signals
  logic [NUM_REQ-1:0]    eligible;
  logic                  grant_found;
  logic                  grant_go;
  logic [PtrW-1:0]       grant_idx;
  logic [PtrW-1:0]       scan_idx;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [1:0]            sel_vc;
  logic [3:0]            sel_type;
  logic [7:0]            sel_seq;

  // Response decode
  logic [7:0]            rsp_id;
  logic                  rsp_id_ok;
  logic                  rsp_hit;
  logic [NUM_REQ-1:0]    rsp_sel;
  logic                  underflow_hit;
  logic                  any_outstanding;

  assign rsp_id    = C0RxHdr_mdata[7:0];
  assign rsp_id_ok = (rsp_id < 8'(NUM_REQ));
  assign rsp_hit   = C0RxRdValid && rsp_id_ok;

  // Eligibility and rotating first-eligible search starting at rr_ptr
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    scan_idx    = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      eligible[i] = req_valid[i] && (cnt_q[i] < MaxOut);
    end
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      scan_idx = PtrW'((32'(rr_ptr_q) + k) % NUM_REQ);
      if (!grant_found && eligible[scan_idx]) begin
        grant_found = 1'b1;
        grant_idx   = scan_idx;
      end
    end
  end

  // Almost-full and enable gate the grant in the same cycle (no skid)
  assign grant_go = arb_enable && !C0TxAlmFull && grant_found;

  // One-hot ready and header mux for the winning requester
  always_comb begin
    sel_addr = '0;
    sel_vc   = '0;
    sel_type = '0;
    sel_seq  = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      req_ready[i] = grant_go && (grant_idx == PtrW'(i));
      if (req_ready[i]) begin
        sel_addr = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        sel_vc   = req_vc[i*2 +: 2];
        sel_type = req_reqtype[i*4 +: 4];
        sel_seq  = seq_q[i];
      end
    end
  end

  // Next-state for Tx header, pointer, per-requester counters and response path
  always_comb begin
    tx_valid_d = grant_go;
    tx_vc_d    = tx_vc_q;
    tx_type_d  = tx_type_q;
    tx_addr_d  = tx_addr_q;
    tx_mdata_d = tx_mdata_q;
    rr_ptr_d   = rr_ptr_q;
    if (grant_go) begin
      tx_vc_d    = sel_vc;
      tx_type_d  = sel_type;
      tx_addr_d  = sel_addr;
      tx_mdata_d = {sel_seq, 8'(grant_idx)};
      rr_ptr_d   = (grant_idx == PtrW'(NUM_REQ - 1)) ? '0 : grant_idx + PtrW'(1);
    end

    underflow_hit = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      rsp_sel[i] = rsp_hit && (rsp_id == 8'(i));
      seq_d[i]   = req_ready[i] ? seq_q[i] + 8'd1 : seq_q[i];
      cnt_d[i]   = cnt_q[i];
      // A response for a requester with nothing in flight strobes but never decrements
      if (rsp_sel[i] && (cnt_q[i] == 8'd0)) begin
        underflow_hit = 1'b1;
      end
      if (req_ready[i] && !(rsp_sel[i] && (cnt_q[i] != 8'd0))) begin
        cnt_d[i] = cnt_q[i] + 8'd1;
      end else if (!req_ready[i] && rsp_sel[i] && (cnt_q[i] != 8'd0)) begin
        cnt_d[i] = cnt_q[i] - 8'd1;
      end
    end

    rsp_valid_d     = rsp_sel;
    rsp_data_d      = rsp_hit ? C0RxData : rsp_data_q;
    rsp_seq_d       = rsp_hit ? C0RxHdr_mdata[15:8] : rsp_seq_q;
    err_badtag_d    = err_badtag_q || (C0RxRdValid && !rsp_id_ok);
    err_underflow_d = err_underflow_q || underflow_hit;
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge SoftReset_n) begin
    if (!SoftReset_n) begin
      rr_ptr_q        <= '0;
      tx_valid_q      <= 1'b0;
      tx_vc_q         <= '0;
      tx_type_q       <= '0;
      tx_addr_q       <= '0;
      tx_mdata_q      <= '0;
      rsp_valid_q     <= '0;
      rsp_data_q      <= '0;
      rsp_seq_q       <= '0;
      err_badtag_q    <= 1'b0;
      err_underflow_q <= 1'b0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        seq_q[i] <= '0;
        cnt_q[i] <= '0;
      end
    end else begin
      rr_ptr_q        <= rr_ptr_d;
      tx_valid_q      <= tx_valid_d;
      tx_vc_q         <= tx_vc_d;
      tx_type_q       <= tx_type_d;
      tx_addr_q       <= tx_addr_d;
      tx_mdata_q      <= tx_mdata_d;
      rsp_valid_q     <= rsp_valid_d;
      rsp_data_q      <= rsp_data_d;
      rsp_seq_q       <= rsp_seq_d;
      err_badtag_q    <= err_badtag_d;
      err_underflow_q <= err_underflow_d;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        seq_q[i] <= seq_d[i];
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  // Packed count output and idle detection
  always_comb begin
    any_outstanding = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      outstanding[i*8 +: 8] = cnt_q[i];
      if (cnt_q[i] != 8'd0) begin
        any_outstanding = 1'b1;
      end
    end
  end

  assign idle            = !any_outstanding && !tx_valid_q;
  assign C0TxRdValid     = tx_valid_q;
  assign C0TxHdr_vc      = tx_vc_q;
  assign C0TxHdr_reqtype = tx_type_q;
  assign C0TxHdr_addr    = tx_addr_q;
  assign C0TxHdr_mdata   = tx_mdata_q;
  assign rsp_valid       = rsp_valid_q;
  assign rsp_data        = rsp_data_q;
  assign rsp_seq         = rsp_seq_q;
  assign err_badtag      = err_badtag_q;
  assign err_underflow   = err_underflow_q;

endmodule

// File: tb/tb_ccip_rdreq_arbiter.sv
// Self-checking bench for ccip_rdreq_arbiter: directed scenarios followed by a
// randomized phase, all compared against a transaction-level reference model.
module tb_ccip_rdreq_arbiter;

  localparam int N    = 4;
  localparam int MAXO = 8;
  localparam int AW   = 42;

  logic            clk = 1'b0;
  logic            SoftReset_n;
  logic            arb_enable;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N*AW-1:0] req_addr;
  logic [N*2-1:0]  req_vc;
  logic [N*4-1:0]  req_reqtype;
  logic            C0TxAlmFull;
  logic            C0TxRdValid;
  logic [1:0]      C0TxHdr_vc;
  logic [3:0]      C0TxHdr_reqtype;
  logic [AW-1:0]   C0TxHdr_addr;
  logic [15:0]     C0TxHdr_mdata;
  logic            C0RxRdValid;
  logic [15:0]     C0RxHdr_mdata;
  logic [511:0]    C0RxData;
  logic [N-1:0]    rsp_valid;
  logic [511:0]    rsp_data;
  logic [7:0]      rsp_seq;
  logic [N*8-1:0]  outstanding;
  logic            idle;
  logic            err_badtag;
  logic            err_underflow;

  always #5 clk = ~clk;

  ccip_rdreq_arbiter #(
    .NUM_REQ        (N),
    .MAX_OUTSTANDING(MAXO),
    .ADDR_WIDTH     (AW)
  ) dut (
    .clk            (clk),
    .SoftReset_n    (SoftReset_n),
    .arb_enable     (arb_enable),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_addr       (req_addr),
    .req_vc         (req_vc),
    .req_reqtype    (req_reqtype),
    .C0TxAlmFull    (C0TxAlmFull),
    .C0TxRdValid    (C0TxRdValid),
    .C0TxHdr_vc     (C0TxHdr_vc),
    .C0TxHdr_reqtype(C0TxHdr_reqtype),
    .C0TxHdr_addr   (C0TxHdr_addr),
    .C0TxHdr_mdata  (C0TxHdr_mdata),
    .C0RxRdValid    (C0RxRdValid),
    .C0RxHdr_mdata  (C0RxHdr_mdata),
    .C0RxData       (C0RxData),
    .rsp_valid      (rsp_valid),
    .rsp_data       (rsp_data),
    .rsp_seq        (rsp_seq),
    .outstanding    (outstanding),
    .idle           (idle),
    .err_badtag     (err_badtag),
    .err_underflow  (err_underflow)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: in-flight counts, next sequence numbers, rotation start, expected registers
  int            m_cnt [N];
  int            m_seq [N];
  int            m_rr;
  logic          m_txv;
  logic [15:0]   m_mdata;
  logic [AW-1:0] m_addr;
  logic [1:0]    m_vc;
  logic [3:0]    m_type;
  logic [N-1:0]  m_rspv;
  logic [511:0]  m_rspd;
  logic [7:0]    m_rsps;
  logic          m_bad;
  logic          m_under;

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_cnt[i] = 0;
      m_seq[i] = 0;
    end
    m_rr    = 0;
    m_txv   = 1'b0;
    m_mdata = '0;
    m_addr  = '0;
    m_vc    = '0;
    m_type  = '0;
    m_rspv  = '0;
    m_rspd  = '0;
    m_rsps  = '0;
    m_bad   = 1'b0;
    m_under = 1'b0;
  endtask

  task automatic check_regs(input string tag);
    logic [N*8-1:0] exp_out;
    int             total;
    total = 0;
    for (int i = 0; i < N; i++) begin
      exp_out[i*8 +: 8] = 8'(m_cnt[i]);
      total += m_cnt[i];
    end
    check({tag, ".txvalid"}, 512'(C0TxRdValid), 512'(m_txv));
    check({tag, ".mdata"}, 512'(C0TxHdr_mdata), 512'(m_mdata));
    check({tag, ".addr"}, 512'(C0TxHdr_addr), 512'(m_addr));
    check({tag, ".vc"}, 512'(C0TxHdr_vc), 512'(m_vc));
    check({tag, ".reqtype"}, 512'(C0TxHdr_reqtype), 512'(m_type));
    check({tag, ".rspvalid"}, 512'(rsp_valid), 512'(m_rspv));
    check({tag, ".rspdata"}, rsp_data, m_rspd);
    check({tag, ".rspseq"}, 512'(rsp_seq), 512'(m_rsps));
    check({tag, ".outstanding"}, 512'(outstanding), 512'(exp_out));
    check({tag, ".idle"}, 512'(idle), 512'((total == 0) && !m_txv));
    check({tag, ".badtag"}, 512'(err_badtag), 512'(m_bad));
    check({tag, ".underflow"}, 512'(err_underflow), 512'(m_under));
  endtask

  // One clock cycle: check combinational ready, advance the model, check registered outputs
  task automatic cycle(input string tag);
    int           win;
    int           idx;
    int           id;
    logic [N-1:0] exp_ready;
    #1;
    win = -1;
    if (arb_enable && !C0TxAlmFull) begin
      for (int k = 0; k < N; k++) begin
        idx = (m_rr + k) % N;
        if (win < 0 && req_valid[idx[1:0]] && m_cnt[idx] < MAXO) win = idx;
      end
    end
    exp_ready = '0;
    if (win >= 0) exp_ready[win[1:0]] = 1'b1;
    check({tag, ".ready"}, 512'(req_ready), 512'(exp_ready));
    @(posedge clk);
    #1;
    m_rspv = '0;
    if (C0RxRdValid) begin
      id = int'(C0RxHdr_mdata[7:0]);
      if (id < N) begin
        m_rspv[id[1:0]] = 1'b1;
        m_rspd = C0RxData;
        m_rsps = C0RxHdr_mdata[15:8];
        if (m_cnt[id] > 0) m_cnt[id]--;
        else m_under = 1'b1;
      end else begin
        m_bad = 1'b1;
      end
    end
    if (win >= 0) begin
      m_txv   = 1'b1;
      m_addr  = req_addr[win*AW +: AW];
      m_vc    = req_vc[win*2 +: 2];
      m_type  = req_reqtype[win*4 +: 4];
      m_mdata = {8'(m_seq[win]), 8'(win)};
      m_seq[win] = (m_seq[win] + 1) % 256;
      m_cnt[win]++;
      m_rr = (win + 1) % N;
    end else begin
      m_txv = 1'b0;
    end
    check_regs(tag);
  endtask

  task automatic do_reset(input string tag);
    #2;
    SoftReset_n = 1'b0;
    model_reset();
    #1;
    check_regs(tag);
    @(posedge clk);
    #1;
    SoftReset_n = 1'b1;
  endtask

  task automatic set_req(input logic [N-1:0] mask);
    req_valid = mask;
    for (int i = 0; i < N; i++) begin
      req_addr[i*AW +: AW]  = AW'(32'h100 + i);
      req_vc[i*2 +: 2]      = 2'(i);
      req_reqtype[i*4 +: 4] = 4'(i);
    end
  endtask

  task automatic send_rsp(input logic [15:0] md);
    C0RxRdValid   = 1'b1;
    C0RxHdr_mdata = md;
    for (int w = 0; w < 16; w++) C0RxData[w*32 +: 32] = $urandom();
  endtask

  task automatic clear_rsp();
    C0RxRdValid = 1'b0;
  endtask

  logic [15:0] s1_exp [5];
  logic [63:0] rnd;
  int          pick;

  initial begin
    s1_exp = '{16'h0000, 16'h0001, 16'h0002, 16'h0003, 16'h0100};
    SoftReset_n   = 1'b0;
    arb_enable    = 1'b0;
    C0TxAlmFull   = 1'b0;
    C0RxRdValid   = 1'b0;
    C0RxHdr_mdata = '0;
    C0RxData      = '0;
    set_req('0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_regs("reset");
    SoftReset_n = 1'b1;

    // All requesters valid: round-robin tag sequence, one per cycle
    arb_enable = 1'b1;
    set_req(4'b1111);
    for (int c = 0; c < 8; c++) begin
      cycle("rr");
      if (c < 5) check("rr.mdata_const", 512'(C0TxHdr_mdata), 512'(s1_exp[c]));
    end
    do_reset("rst1");

    // Credit limit on requester 2, then one response releases one credit
    set_req(4'b0100);
    for (int c = 0; c < 10; c++) cycle("credit");
    check("credit.full", 512'(outstanding[23:16]), 512'(8'd8));
    send_rsp(16'h0002);
    cycle("credit.rsp");
    clear_rsp();
    check("credit.rspvalid", 512'(rsp_valid), 512'(4'b0100));
    cycle("credit.again");
    check("credit.again_mdata", 512'(C0TxHdr_mdata), 512'(16'h0802));
    do_reset("rst2");

    // Almost-full stall then resume from the saved pointer
    set_req(4'b1111);
    cycle("af.pre");
    cycle("af.pre");
    C0TxAlmFull = 1'b1;
    for (int c = 0; c < 5; c++) cycle("af.stall");
    C0TxAlmFull = 1'b0;
    cycle("af.resume");
    check("af.resume_id", 512'(C0TxHdr_mdata[7:0]), 512'(8'd2));
    for (int c = 0; c < 3; c++) cycle("af.post");
    do_reset("rst3");

    // Bad tag: dropped, sticky error until reset
    set_req('0);
    send_rsp(16'h0305);
    cycle("bad");
    clear_rsp();
    check("bad.flag", 512'(err_badtag), 512'(1'b1));
    for (int c = 0; c < 3; c++) cycle("bad.hold");
    do_reset("rst4");

    // Simultaneous grant and response on requester 1
    set_req(4'b0010);
    for (int c = 0; c < 3; c++) cycle("sim.fill");
    send_rsp(16'h0001);
    cycle("sim.both");
    clear_rsp();
    check("sim.count", 512'(outstanding[15:8]), 512'(8'd3));
    do_reset("rst5");

    // Disable with requests in flight, drain to idle, then async reset mid-stream
    set_req(4'b1111);
    for (int c = 0; c < 3; c++) cycle("drain.fill");
    arb_enable = 1'b0;
    cycle("drain.off");
    for (int i = 0; i < 3; i++) begin
      send_rsp({8'(i), 8'(i)});
      cycle("drain.rsp");
    end
    clear_rsp();
    cycle("drain.end");
    check("drain.idle", 512'(idle), 512'(1'b1));
    arb_enable = 1'b1;
    cycle("mid.fill");
    cycle("mid.fill");
    do_reset("mid.rst");
    check("mid.idle", 512'(idle), 512'(1'b1));
    send_rsp(16'h0000);
    cycle("post.rsp");
    clear_rsp();
    check("post.underflow", 512'(err_underflow), 512'(1'b1));
    do_reset("rst6");

    // Randomized traffic
    for (int c = 0; c < 400; c++) begin
      req_valid   = N'($urandom());
      arb_enable  = ($urandom_range(0, 9) != 0);
      C0TxAlmFull = ($urandom_range(0, 4) == 0);
      for (int i = 0; i < N; i++) begin
        rnd = {$urandom(), $urandom()};
        req_addr[i*AW +: AW]  = rnd[AW-1:0];
        req_vc[i*2 +: 2]      = rnd[63:62];
        req_reqtype[i*4 +: 4] = rnd[61:58];
      end
      clear_rsp();
      if ($urandom_range(0, 19) == 0) begin
        send_rsp({8'($urandom()), 8'($urandom_range(0, 7))});
      end else if ($urandom_range(0, 9) < 4) begin
        pick = $urandom_range(0, N - 1);
        if (m_cnt[pick] > 0) send_rsp({8'($urandom()), 8'(pick)});
      end
      cycle("rand");
    end
    clear_rsp();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ccip_rdreq_arbiter.md
Name: ccip_rdreq_arbiter

Overview:
- Shares the single AFU C0 Tx read-request channel between NUM_REQ independent requesters using round-robin arbitration.
- Tags each request's mdata with its requester ID and a per-requester sequence number, and enforces per-requester outstanding-read credits.
- Steers C0 Rx read responses back to the originating requester.
- Sits between AFU sub-engines and the CCI-P C0 Tx/Rx ports; its Tx outputs feed the transaction logger unchanged.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- MAX_OUTSTANDING, 8, per-requester outstanding read limit (1..255).
- ADDR_WIDTH, 42, cache-line address width.

Ports:
- clk  in  1  clock.
- SoftReset_n  in  1  reset, asynchronous assert, active-low.
- arb_enable  in  1  when 0, no new grants; in-flight responses are still routed.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  per-requester accept, combinational.
- req_addr  in  NUM_REQ*ADDR_WIDTH  packed request addresses; requester i at slice i.
- req_vc  in  NUM_REQ*2  packed virtual-channel select.
- req_reqtype  in  NUM_REQ*4  packed request type (RdLine_S/I/E encodings).
- C0TxAlmFull  in  1  Tx channel almost full.
- C0TxRdValid  out  1  registered read-request valid.
- C0TxHdr_vc  out  2  registered request VC.
- C0TxHdr_reqtype  out  4  registered request type.
- C0TxHdr_addr  out  ADDR_WIDTH  registered request address.
- C0TxHdr_mdata  out  16  registered tag: {seq[7:0], id[7:0]}.
- C0RxRdValid  in  1  read response valid.
- C0RxHdr_mdata  in  16  response tag.
- C0RxData  in  512  response data.
- rsp_valid  out  NUM_REQ  registered one-hot response strobe.
- rsp_data  out  512  registered response data, shared by all requesters.
- rsp_seq  out  8  registered response sequence number.
- outstanding  out  NUM_REQ*8  packed per-requester in-flight counts.
- idle  out  1  all outstanding counts are 0 and C0TxRdValid is 0.
- err_badtag  out  1  sticky: response received with id >= NUM_REQ.
- err_underflow  out  1  sticky: response received for a requester with count 0.

Behaviour:
- Reset values: every output register 0; rr_ptr=0; all seq and outstanding counts 0; idle=1.
- Eligibility: requester i is eligible when req_valid[i] & (outstanding[i] < MAX_OUTSTANDING).
- Grant qualification: a grant is issued only when arb_enable & !C0TxAlmFull & at least one requester is eligible.
- Grant selection: the first eligible requester searching from rr_ptr upward with wrap. req_ready is one-hot on the winner and 0 otherwise.
- Accept (req_valid[i] & req_ready[i]), then next cycle:
  - C0TxRdValid=1 with the header fields from slice i, and mdata={seq[i], i[7:0]};
  - seq[i] increments, wrapping 255->0;
  - rr_ptr advances to (i+1) mod NUM_REQ.
- No accept: C0TxRdValid=0 next cycle; header fields hold their previous values.
- Latency: request to Tx is exactly 1 cycle. At most one request per cycle.
- Almost-full: C0TxAlmFull is sampled combinationally. Asserting it blocks the grant in that same cycle; there is no request skid.
- Response path: when C0RxRdValid is high, id=C0RxHdr_mdata[7:0].
  - id < NUM_REQ: next cycle rsp_valid[id]=1, rsp_data=C0RxData, rsp_seq=mdata[15:8]; outstanding[id] decrements.
  - id >= NUM_REQ: response dropped, err_badtag set.
  - id valid but outstanding[id]==0: rsp_valid still strobes, count stays 0, err_underflow set.
- Simultaneous grant and response for the same requester: count unchanged.
- Counts never exceed MAX_OUTSTANDING and never go below 0.
- Sticky error flags clear only on reset.
- arb_enable deasserted mid-stream: the in-flight registered request still issues; responses keep draining; idle asserts once all counts reach 0.
- Reset asserted mid-operation: all state clears immediately (asynchronous); responses arriving after reset with count 0 set err_underflow.

Test Plan:
- All 4 requesters hold valid continuously, addr i=0x100+i, no AlmFull -> Tx mdata sequence 0x0000, 0x0001, 0x0002, 0x0003, 0x0100, 0x0101...; one request per cycle, each 1 cycle after its accept.
- Requester 2 only, MAX_OUTSTANDING=8, no responses -> exactly 8 accepts, then req_ready[2]=0 and outstanding[2]=8. One response with mdata=0x0002 -> rsp_valid=4'b0100 next cycle, one more accept allowed.
- C0TxAlmFull=1 for 5 cycles with all requesters valid -> req_ready=0 and C0TxRdValid=0 in the cycle after each blocked cycle; grants resume in rr order from the saved pointer.
- Response with mdata=0x0305 (NUM_REQ=4) -> no rsp_valid, err_badtag=1 and stays 1 until SoftReset_n=0.
- Grant to requester 1 and response id=1 in the same cycle with outstanding[1]=3 -> outstanding[1] remains 3.
- 3 requests in flight, arb_enable=0 -> no new Tx; after 3 responses idle=1. Then assert SoftReset_n=0 mid-stream -> all outputs 0 asynchronously and idle=1.
